// File: rtl/ss_bus_master_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : ssbus_if                                                   |
// | Brief    : Save-state bus between the ss_bus_master and the slaves    |
// |            (tile mappers, register banks, sprite/line controllers).   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface ssbus_if;
   logic [7:0]  select;
   logic [23:0] addr;
   logic [63:0] data;
   logic        query;
   logic        read;
   logic        write;
   logic        ack;
   logic [23:0] query_count;
   logic [63:0] data_in;

   modport master (
      output select, addr, data, query, read, write,
      input  ack, query_count, data_in
   );

   modport slave (
      input  select, addr, data, query, read, write,
      output ack, query_count, data_in
   );
endinterface
`default_nettype wire

// File: rtl/ss_bus_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : ss_bus_master                                              |
// | Brief    : Save-state initiator. Save walks device indices, queries   |
// |            each slave's word count and streams header + payload words |
// |            to memory, closing with a terminator. Restore reads the    |
// |            same stream back and writes each word into its slave.      |
// | Options  : SS_CHECKSUM_EN - append/verify a 64-bit XOR of all payload |
// |            words after the terminator.                                |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module ss_bus_master #(
   parameter int          MAX_DEV   = 128,
   parameter int          TIMEOUT   = 255,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          save_start,
   input  logic          restore_start,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [31:0]   mem_addr,
   output logic [63:0]   mem_wdata,
   input  logic [63:0]   mem_rdata,
   output logic          mem_wr,
   output logic          mem_rd,
   input  logic          mem_ack,
   ssbus_if.master       ssbus
);

   // Timeout counter is at least 8 bits, wider only if TIMEOUT needs it.
   localparam int                 C_TMO_W     = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [C_TMO_W-1:0] C_TMO_LIMIT = C_TMO_W'(TIMEOUT);
   localparam logic [7:0]         C_LAST_IDX  = 8'(MAX_DEV - 1);
   localparam logic [7:0]         C_MAGIC     = 8'hA5;
   localparam logic [63:0]        C_TERM      = 64'h5A00_0000_0000_0000;
   localparam logic [31:0]        C_STEP      = 32'd8;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_QUERY = 4'd1,
      S_HDR   = 4'd2,
      S_RD    = 4'd3,
      S_MWR   = 4'd4,
      S_MRD   = 4'd5,
      S_WR    = 4'd6,
      S_NEXT  = 4'd7,
      S_FIN   = 4'd8,
      S_CSUM  = 4'd9,
      S_ERROR = 4'd10
   } state_t;

   state_t               r_state, w_state;

   logic                 r_save,      w_save;
   logic [7:0]           r_idx,       w_idx;
   logic [23:0]          r_count,     w_count;
   logic [23:0]          r_n,         w_n;
   logic [C_TMO_W-1:0]   r_tmo,       w_tmo;
   logic [31:0]          r_mem_addr,  w_mem_addr;
   logic [63:0]          r_mem_wdata, w_mem_wdata;
   logic                 r_mem_wr,    w_mem_wr;
   logic                 r_mem_rd,    w_mem_rd;
   logic                 r_busy,      w_busy;
   logic                 r_done,      w_done;
   logic                 r_error,     w_error;
   logic                 r_query,     w_query;
   logic                 r_read,      w_read;
   logic                 r_write,     w_write;
   logic [7:0]           r_select,    w_select;
   logic [23:0]          r_addr,      w_addr;
   logic [63:0]          r_data,      w_data;
`ifdef SS_CHECKSUM_EN
   logic [63:0]          r_csum,      w_csum;
`endif

   logic [23:0]          w_n_inc;
   logic                 w_tmo_exp;
   logic                 w_hdr_ok;

   assign w_n_inc   = r_n + 24'd1;
   assign w_tmo_exp = (r_tmo == C_TMO_LIMIT);
   // Restore header must carry the magic byte, this index and the live count.
   assign w_hdr_ok  = (mem_rdata[63:56] == C_MAGIC) &&
                      (mem_rdata[39:32] == r_idx)   &&
                      (mem_rdata[23:0]  == r_count);

   assign busy          = r_busy;
   assign done          = r_done;
   assign error         = r_error;
   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign mem_wr        = r_mem_wr;
   assign mem_rd        = r_mem_rd;
   assign ssbus.select  = r_select;
   assign ssbus.addr    = r_addr;
   assign ssbus.data    = r_data;
   assign ssbus.query   = r_query;
   assign ssbus.read    = r_read;
   assign ssbus.write   = r_write;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   // Datapath and registered outputs; every strobe comes straight from a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_save      <= 1'b0;
         r_idx       <= 8'd0;
         r_count     <= 24'd0;
         r_n         <= 24'd0;
         r_tmo       <= '0;
         r_mem_addr  <= BASE_ADDR;
         r_mem_wdata <= 64'd0;
         r_mem_wr    <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_query     <= 1'b0;
         r_read      <= 1'b0;
         r_write     <= 1'b0;
         r_select    <= 8'd0;
         r_addr      <= 24'd0;
         r_data      <= 64'd0;
`ifdef SS_CHECKSUM_EN
         r_csum      <= 64'd0;
`endif
      end else begin
         r_save      <= w_save;
         r_idx       <= w_idx;
         r_count     <= w_count;
         r_n         <= w_n;
         r_tmo       <= w_tmo;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_mem_wr    <= w_mem_wr;
         r_mem_rd    <= w_mem_rd;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_error     <= w_error;
         r_query     <= w_query;
         r_read      <= w_read;
         r_write     <= w_write;
         r_select    <= w_select;
         r_addr      <= w_addr;
         r_data      <= w_data;
`ifdef SS_CHECKSUM_EN
         r_csum      <= w_csum;
`endif
      end
   end

   // Next-state and next-register logic. A strobe is raised on the
   // transition into the state that owns it and dropped on the ack, so
   // there is always at least one idle cycle between successive strobes.
   always_comb begin
      w_state     = r_state;
      w_save      = r_save;
      w_idx       = r_idx;
      w_count     = r_count;
      w_n         = r_n;
      w_tmo       = r_tmo + 1'b1;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_mem_wr    = r_mem_wr;
      w_mem_rd    = r_mem_rd;
      w_busy      = r_busy;
      w_done      = 1'b0;
      w_error     = r_error;
      w_query     = r_query;
      w_read      = r_read;
      w_write     = r_write;
      w_select    = r_select;
      w_addr      = r_addr;
      w_data      = r_data;
`ifdef SS_CHECKSUM_EN
      w_csum      = r_csum;
`endif

      case (r_state)
         S_IDLE: begin
            if (save_start || restore_start) begin
               w_save     = save_start;
               w_idx      = 8'd0;
               w_error    = 1'b0;
               w_busy     = 1'b1;
               w_mem_addr = BASE_ADDR;
               w_select   = 8'd0;
               w_addr     = 24'd0;
               w_query    = 1'b1;
               w_tmo      = '0;
`ifdef SS_CHECKSUM_EN
               w_csum     = 64'd0;
`endif
               w_state    = S_QUERY;
            end
         end

         S_QUERY: begin
            if (ssbus.ack) begin
               w_query = 1'b0;
               w_count = ssbus.query_count;
               if (ssbus.query_count == 24'd0) begin
                  w_state = S_NEXT;
               end else begin
                  w_state = S_HDR;
                  if (r_save) begin
                     w_mem_wr    = 1'b1;
                     w_mem_wdata = {C_MAGIC, 16'h0000, r_idx, 8'h00, ssbus.query_count};
                  end else begin
                     w_mem_rd    = 1'b1;
                  end
               end
            end else if (w_tmo_exp) begin
               // No slave at this index; not an error.
               w_query = 1'b0;
               w_state = S_NEXT;
            end
         end

         S_HDR: begin
            if (mem_ack) begin
               w_mem_wr   = 1'b0;
               w_mem_rd   = 1'b0;
               w_mem_addr = r_mem_addr + C_STEP;
               w_n        = 24'd0;
               if (r_save) begin
                  w_read  = 1'b1;
                  w_addr  = 24'd0;
                  w_tmo   = '0;
                  w_state = S_RD;
               end else if (!w_hdr_ok) begin
                  w_state = S_ERROR;
               end else begin
                  w_mem_rd = 1'b1;
                  w_state  = S_MRD;
               end
            end
         end

         S_RD: begin
            if (ssbus.ack) begin
               w_read      = 1'b0;
               w_mem_wdata = ssbus.data_in;
               w_mem_wr    = 1'b1;
               w_state     = S_MWR;
            end else if (w_tmo_exp) begin
               w_read  = 1'b0;
               w_state = S_ERROR;
            end
         end

         S_MWR: begin
            if (mem_ack) begin
               w_mem_wr   = 1'b0;
               w_mem_addr = r_mem_addr + C_STEP;
               w_n        = w_n_inc;
`ifdef SS_CHECKSUM_EN
               w_csum     = r_csum ^ r_mem_wdata;
`endif
               if (w_n_inc == r_count) begin
                  w_state = S_NEXT;
               end else begin
                  w_read  = 1'b1;
                  w_addr  = w_n_inc;
                  w_tmo   = '0;
                  w_state = S_RD;
               end
            end
         end

         S_MRD: begin
            if (mem_ack) begin
               w_mem_rd   = 1'b0;
               w_mem_addr = r_mem_addr + C_STEP;
               w_data     = mem_rdata;
`ifdef SS_CHECKSUM_EN
               w_csum     = r_csum ^ mem_rdata;
`endif
               w_addr     = r_n;
               w_write    = 1'b1;
               w_tmo      = '0;
               w_state    = S_WR;
            end
         end

         S_WR: begin
            if (ssbus.ack) begin
               w_write = 1'b0;
               w_n     = w_n_inc;
               if (w_n_inc == r_count) begin
                  w_state = S_NEXT;
               end else begin
                  w_mem_rd = 1'b1;
                  w_state  = S_MRD;
               end
            end else if (w_tmo_exp) begin
               w_write = 1'b0;
               w_state = S_ERROR;
            end
         end

         S_NEXT: begin
            if (r_idx == C_LAST_IDX) begin
               w_state = S_FIN;
               if (r_save) begin
                  w_mem_wr    = 1'b1;
                  w_mem_wdata = C_TERM;
               end else begin
                  w_mem_rd    = 1'b1;
               end
            end else begin
               w_idx    = r_idx + 8'd1;
               w_select = r_idx + 8'd1;
               w_addr   = 24'd0;
               w_query  = 1'b1;
               w_tmo    = '0;
               w_state  = S_QUERY;
            end
         end

         S_FIN: begin
            if (mem_ack) begin
               w_mem_wr   = 1'b0;
               w_mem_rd   = 1'b0;
               w_mem_addr = r_mem_addr + C_STEP;
               if (!r_save && (mem_rdata != C_TERM)) begin
                  w_state = S_ERROR;
               end else begin
`ifdef SS_CHECKSUM_EN
                  w_state = S_CSUM;
                  if (r_save) begin
                     w_mem_wr    = 1'b1;
                     w_mem_wdata = r_csum;
                  end else begin
                     w_mem_rd    = 1'b1;
                  end
`else
                  w_done  = 1'b1;
                  w_busy  = 1'b0;
                  w_state = S_IDLE;
`endif
               end
            end
         end

`ifdef SS_CHECKSUM_EN
         S_CSUM: begin
            if (mem_ack) begin
               w_mem_wr   = 1'b0;
               w_mem_rd   = 1'b0;
               w_mem_addr = r_mem_addr + C_STEP;
               if (!r_save && (mem_rdata != r_csum)) begin
                  w_state = S_ERROR;
               end else begin
                  w_done  = 1'b1;
                  w_busy  = 1'b0;
                  w_state = S_IDLE;
               end
            end
         end
`endif

         S_ERROR: begin
            w_mem_wr = 1'b0;
            w_mem_rd = 1'b0;
            w_query  = 1'b0;
            w_read   = 1'b0;
            w_write  = 1'b0;
            w_error  = 1'b1;
            w_busy   = 1'b0;
            w_state  = S_IDLE;
         end

         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ss_bus_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_ss_bus_master                                           |
// | Brief    : Scoreboard bench for ss_bus_master with a memory model and |
// |            two behavioural slaves (idx 3: 8 words, idx 9: 2 words).   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_ss_bus_master;

   localparam int          MAX_DEV = 12;
   localparam int          TIMEOUT = 15;
   localparam logic [31:0] BASE    = 32'h0000_1000;

   localparam int K_MEMWR = 1;
   localparam int K_SSWR  = 2;
   localparam int K_DONE  = 3;
   localparam int K_ERR   = 4;

   localparam logic [63:0] HDR3  = 64'hA500_0003_0000_0008;
   localparam logic [63:0] HDR9  = 64'hA500_0009_0000_0002;
   localparam logic [63:0] S9W0  = 64'hDEAD_BEEF_0000_0009;
   localparam logic [63:0] S9W1  = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] TERM  = 64'h5A00_0000_0000_0000;
   localparam logic [63:0] CSUM  = 64'hDF8E_FB88_89AB_CDE6;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [63:0] d;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset, save_start, restore_start;
   logic        busy, done, error;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
   logic        mem_wr, mem_rd, mem_ack;

   ssbus_if ss ();

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;
   logic mon_en;

   logic [63:0] mem [64];
   logic        poke;
   logic [5:0]  poke_idx;
   logic [63:0] poke_val;
   logic [5:0]  m_idx;

   logic [63:0] sregs [16][8];
   logic        slv_load, slv_clr, hold5;

   always #5 clk = ~clk;

   ss_bus_master #(.MAX_DEV(MAX_DEV), .TIMEOUT(TIMEOUT), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .save_start(save_start), .restore_start(restore_start),
      .busy(busy), .done(done), .error(error),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_ack(mem_ack), .ssbus(ss)
   );

   assign m_idx = 6'((mem_addr - BASE) >> 3);

   // Memory: one-cycle-latency single-pulse ack.
   always @(posedge clk) begin
      mem_ack <= 1'b0;
      if (poke) mem[poke_idx] <= poke_val;
      if (!reset && (mem_wr || mem_rd) && !mem_ack) begin
         mem_ack <= 1'b1;
         if (mem_wr) mem[m_idx] <= mem_wdata;
         else        mem_rdata  <= mem[m_idx];
      end
   end

   // Slaves at idx 3 and 9; every other index stays silent.
   always @(posedge clk) begin
      ss.ack <= 1'b0;
      if (slv_load || slv_clr) begin
         for (int i = 0; i < 16; i++)
            for (int j = 0; j < 8; j++)
               sregs[i][j] <= 64'd0;
         if (slv_load) begin
            for (int j = 0; j < 8; j++) sregs[3][j] <= 64'h10 + 64'(j);
            sregs[9][0] <= S9W0;
            sregs[9][1] <= S9W1;
         end
      end else if (!reset && (ss.query || ss.read || ss.write) && !ss.ack &&
                   (ss.select == 8'd3 || ss.select == 8'd9) &&
                   !(hold5 && ss.read && ss.select == 8'd3 && ss.addr == 24'd5)) begin
         ss.ack <= 1'b1;
         if (ss.query) ss.query_count <= (ss.select == 8'd3) ? 24'd8 : 24'd2;
         if (ss.read)  ss.data_in <= sregs[ss.select[3:0]][ss.addr[2:0]];
         if (ss.write) sregs[ss.select[3:0]][ss.addr[2:0]] <= ss.data;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [63:0] d);
      ev_t e;
      e.kind = kind; e.a = a; e.d = d;
      q.push_back(e);
   endtask

   task automatic take_ev(input int kind, input logic [31:0] a, input logic [63:0] d);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d addr %h data %h, required none", kind, a, d);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.a !== a || e.d !== d) begin
            errors++;
            $display("FAIL event: got kind %0d addr %h data %h, required kind %0d addr %h data %h",
                     kind, a, d, e.kind, e.a, e.d);
         end
      end
   endtask

   task automatic push_save_image();
      push(K_MEMWR, BASE, HDR3);
      for (int i = 0; i < 8; i++) push(K_MEMWR, BASE + 32'(8 * (i + 1)), 64'h10 + 64'(i));
      push(K_MEMWR, BASE + 32'h48, HDR9);
      push(K_MEMWR, BASE + 32'h50, S9W0);
      push(K_MEMWR, BASE + 32'h58, S9W1);
      push(K_MEMWR, BASE + 32'h60, TERM);
`ifdef SS_CHECKSUM_EN
      push(K_MEMWR, BASE + 32'h68, CSUM);
`endif
   endtask

   task automatic push_restore_writes(input logic [63:0] word1);
      for (int i = 0; i < 8; i++)
         push(K_SSWR, {8'd3, 24'(i)}, (i == 1) ? word1 : 64'h10 + 64'(i));
      push(K_SSWR, {8'd9, 24'd0}, S9W0);
      push(K_SSWR, {8'd9, 24'd1}, S9W1);
   endtask

   task automatic pulse(input logic sv, input logic rs);
      save_start = sv; restore_start = rs;
      @(negedge clk);
      save_start = 1'b0; restore_start = 1'b0;
   endtask

   task automatic do_poke(input int idx, input logic [63:0] val);
      poke = 1'b1; poke_idx = 6'(idx); poke_val = val;
      @(negedge clk);
      poke = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(done || error) && n < 2000);
      chk({name, "_ended"}, 64'(done | error), 64'd1);
   endtask

   // Monitor: pops the scoreboard on every observable DUT event.
   initial begin : monitor
      logic err_q;
      err_q = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && !reset) begin
            if (mem_wr && mem_ack)  take_ev(K_MEMWR, mem_addr, mem_wdata);
            if (ss.write && ss.ack) take_ev(K_SSWR, {ss.select, ss.addr}, ss.data);
            if (done)               take_ev(K_DONE, 32'd0, 64'd0);
            if (error && !err_q)    take_ev(K_ERR, 32'd0, 64'd0);
            if (busy) chk("strobe_onehot", 64'($countones({ss.query, ss.read, ss.write}) <= 1), 64'd1);
         end
         err_q = error;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int rd_hi;
      int n;
      mon_en = 1'b0; hold5 = 1'b0; poke = 1'b0; poke_idx = 6'd0; poke_val = 64'd0;
      slv_clr = 1'b0; slv_load = 1'b1; reset = 1'b1;
      save_start = 1'b0; restore_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_mem_wr", 64'(mem_wr), 64'd0);
      chk("rst_mem_rd", 64'(mem_rd), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'(BASE));
      chk("rst_strobes", 64'({ss.query, ss.read, ss.write}), 64'd0);
      chk("rst_select", 64'(ss.select), 64'd0);
      chk("rst_addr", 64'(ss.addr), 64'd0);
      slv_load = 1'b0; reset = 1'b0; mon_en = 1'b1;
      @(negedge clk);

      // Save with both starts in the same cycle, then a start while busy.
      push_save_image();
      push(K_DONE, 32'd0, 64'd0);
      pulse(1'b1, 1'b1);
      @(negedge clk);
      chk("save_busy", 64'(busy), 64'd1);
      pulse(1'b1, 1'b0);
      wait_end("save");
      chk("save_error", 64'(error), 64'd0);
      repeat (20) @(negedge clk);
      chk("save_drained", 64'(q.size()), 64'd0);
      chk("save_idle", 64'(busy), 64'd0);

      // Restore into cleared slaves.
      slv_clr = 1'b1; @(negedge clk); slv_clr = 1'b0;
      push_restore_writes(64'h11);
`ifdef SS_CHECKSUM_EN
      push(K_DONE, 32'd0, 64'd0);
`else
      push(K_DONE, 32'd0, 64'd0);
`endif
      pulse(1'b0, 1'b1);
      wait_end("restore");
      chk("restore_error", 64'(error), 64'd0);
      repeat (20) @(negedge clk);
      chk("restore_drained", 64'(q.size()), 64'd0);
      for (int i = 0; i < 8; i++) chk("slave3_reg", sregs[3][i], 64'h10 + 64'(i));
      chk("slave9_reg1", sregs[9][1], S9W1);

      // Corrupted header magic: error, no slave write.
      do_poke(0, 64'h0000_0003_0000_0008);
      push(K_ERR, 32'd0, 64'd0);
      pulse(1'b0, 1'b1);
      wait_end("bad_hdr");
      chk("bad_hdr_error", 64'(error), 64'd1);
      chk("bad_hdr_busy", 64'(busy), 64'd0);
      repeat (20) @(negedge clk);
      chk("bad_hdr_drained", 64'(q.size()), 64'd0);
      do_poke(0, HDR3);

      // Slave 3 withholds ack on addr 5 during save.
      hold5 = 1'b1;
      push(K_MEMWR, BASE, HDR3);
      for (int i = 0; i < 5; i++) push(K_MEMWR, BASE + 32'(8 * (i + 1)), 64'h10 + 64'(i));
      push(K_ERR, 32'd0, 64'd0);
      pulse(1'b1, 1'b0);
      rd_hi = 0; n = 0;
      do begin
         @(negedge clk);
         n++;
         if (ss.read && ss.select == 8'd3 && ss.addr == 24'd5) rd_hi++;
      end while (!(done || error) && n < 2000);
      chk("tmo_error", 64'(error), 64'd1);
      chk("tmo_read_low", 64'(ss.read), 64'd0);
      chk("tmo_busy", 64'(busy), 64'd0);
      if (rd_hi < TIMEOUT || rd_hi > TIMEOUT + 2) chk("tmo_window", 64'(rd_hi), 64'(TIMEOUT + 1));
      else chk("tmo_window", 64'd1, 64'd1 & 64'(rd_hi >= TIMEOUT));
      repeat (20) @(negedge clk);
      chk("tmo_drained", 64'(q.size()), 64'd0);
      hold5 = 1'b0;

`ifdef SS_CHECKSUM_EN
      // One payload bit flipped: writes happen, checksum fails, no done.
      do_poke(2, 64'h10);
      push_restore_writes(64'h10);
      push(K_ERR, 32'd0, 64'd0);
      pulse(1'b0, 1'b1);
      wait_end("csum");
      chk("csum_error", 64'(error), 64'd1);
      repeat (20) @(negedge clk);
      chk("csum_drained", 64'(q.size()), 64'd0);
`endif

      // Reset in the middle of a save aborts to reset values.
      mon_en = 1'b0;
      pulse(1'b1, 1'b0);
      repeat (40) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_mem_strobes", 64'({mem_wr, mem_rd}), 64'd0);
      chk("midrst_ss_strobes", 64'({ss.query, ss.read, ss.write}), 64'd0);
      chk("midrst_mem_addr", 64'(mem_addr), 64'(BASE));
      reset = 1'b0;
      q.delete();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ss_bus_master.md
Name: ss_bus_master

Overview:
- Save-state initiator for the ssbus: the master side of the bus that every state-holding block (tile mappers, register banks, sprite/line controllers) exposes as a slave.
- On a save request it walks device indices 0..MAX_DEV-1, queries each slave's word count, reads every word and streams the words to a state-memory port.
- On a restore request it reads the same stream back from memory and writes each word into the matching slave.
- Sits between the top-level save-state/OSD logic and the slave chain, one instance per core.

Parameters:
MAX_DEV, 128, number of device indices scanned (select width 8 bits, so MAX_DEV ≤ 256).
TIMEOUT, 255, cycles to wait for a slave ack before giving up.
BASE_ADDR, 0, 32-bit byte address of the first memory word.

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
save_start  in  1  one-cycle pulse, begin save
restore_start  in  1  one-cycle pulse, begin restore
busy  out  1  operation in progress
done  out  1  one-cycle pulse at successful end
error  out  1  sticky until next start; set on timeout or bad header
mem_addr  out  32  byte address, 8-byte aligned
mem_wdata  out  64  word to store
mem_rdata  in  64  word loaded
mem_wr  out  1  write request, held until mem_ack
mem_rd  out  1  read request, held until mem_ack
mem_ack  in  1  one-cycle completion; mem_rdata valid with it
ssbus  ssbus_if.master  -  select[7:0], addr[23:0], data[63:0], query, read, write out; ack, query_count[23:0], data_in[63:0] in

Behaviour:
- Reset: busy=0, done=0, error=0, mem_wr=0, mem_rd=0, mem_addr=BASE_ADDR, ssbus query/read/write=0, select=0, addr=0.
- States:
  - IDLE: waits for save_start or restore_start. If both pulse in the same cycle, save wins. Starts are ignored while busy.
  - QUERY: asserts query with select=idx, held until ack or TIMEOUT cycles.
    - ack: latch count=query_count.
    - Timeout: device absent. Skip to NEXT. This is not an error.
    - count==0: skip to NEXT.
  - HDR:
    - Save: writes header word {8'hA5, 16'b0, idx[7:0], 8'b0, count[23:0]}; address +8 after mem_ack.
    - Restore: reads a header and requires byte7==A5, idx match and count match; any mismatch → ERROR.
  - XFER loop, word n = 0..count-1:
    - Save: ssbus read with addr=n until ack, latch data_in, then mem write.
    - Restore: mem read, then ssbus write with data=mem_rdata until ack.
    - Exactly one of query/read/write is high at a time.
    - Each strobe drops the cycle after ack; the next strobe may rise no earlier than the following cycle.
    - An ssbus timeout inside XFER → ERROR.
  - NEXT: idx+1. If idx==MAX_DEV-1, go to FINISH.
  - FINISH: save writes terminator word 64'h5A00_0000_0000_0000; restore reads the terminator and checks it (mismatch → ERROR). Then done pulses for 1 cycle and the block goes to IDLE.
  - ERROR: drops all strobes, sets error=1, returns to IDLE. No done pulse.
- Memory address increments by 8 per acknowledged word and wraps at 2^32 silently.
- busy=1 from the cycle after an accepted start until the cycle done or error asserts.
- mem_ack with no request outstanding is ignored. An ssbus ack outside a pending strobe is ignored.
- A reset mid-operation aborts immediately to reset values. A partial image in memory is not cleaned up.
- Timeout counter is 8+ bits, cleared on every new strobe; it expires when count==TIMEOUT with no ack.

Optional Feature:
SS_CHECKSUM_EN:
- Defined: a 64-bit running XOR over all payload words (headers excluded).
  - Save: checksum word is written immediately after the terminator.
  - Restore: the checksum word is read after the terminator and compared; mismatch → error=1 and no done pulse. Slave writes already done are not undone.
- Undefined: no checksum logic. The stream ends at the terminator.

Test Plan:
- Save, with slaves idx 3 (count 8, words 0..7 = 0x10..0x17) and idx 9 (count 2), all others absent → memory: header A5..03..000008, 8 payload words, header for idx 9, 2 words, terminator; done=1 once; error=0.
- Restore of that image into cleared slaves → slave 3 registers read back 0x10..0x17; done pulses once.
- Restore with corrupted header byte7=0x00 → error=1 after the first header read; no ssbus write issued; busy drops.
- Slave 3 withholds ack on addr 5 during save → after TIMEOUT cycles error=1; read strobe deasserted.
- save_start and restore_start pulsed in the same cycle → save performed. A second save_start while busy has no effect.
- With SS_CHECKSUM_EN, flip one payload bit in memory, then restore → error=1, done=0.
